// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multicycle RV32I control unit: states, opcodes and mux selects.
// Both the top-level FSM and the ALU decoder import this package.
package multicycle_control_fsm_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecuteR,
        StExecuteI,
        StAluWb,
        StJal,
        StBranch,
        StTrap
    } state_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRtype  = 7'b0110011;
    localparam logic [6:0] OpItype  = 7'b0010011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpBranch = 7'b1100011;

    typedef enum logic [2:0] {
        ImmI = 3'b000,
        ImmS = 3'b001,
        ImmB = 3'b010,
        ImmJ = 3'b100
    } imm_src_e;

    typedef enum logic [2:0] {
        AluAdd = 3'b000,
        AluSub = 3'b001,
        AluAnd = 3'b010,
        AluOr  = 3'b011,
        AluSlt = 3'b101
    } alu_control_e;

    typedef enum logic [1:0] {
        AluOpAdd   = 2'b00,
        AluOpSub   = 2'b01,
        AluOpFunct = 2'b10
    } alu_op_e;

    typedef enum logic [1:0] {
        ResAluOut    = 2'b00,
        ResData      = 2'b01,
        ResAluResult = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        SrcAPc    = 2'b00,
        SrcAOldPc = 2'b01,
        SrcARs1   = 2'b10
    } src_a_e;

    typedef enum logic [1:0] {
        SrcBRs2  = 2'b00,
        SrcBImm  = 2'b01,
        SrcBFour = 2'b10
    } src_b_e;

    // Unknown opcodes fall back to the I-type layout.
    function automatic imm_src_e imm_src_of(input logic [6:0] op);
        case (op)
            OpStore:  return ImmS;
            OpBranch: return ImmB;
            OpJal:    return ImmJ;
            default:  return ImmI;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_alu_decoder.sv
// Combinational ALU control decode from the FSM's alu_op and the instruction funct fields.
module multicycle_control_fsm_alu_decoder
    import multicycle_control_fsm_pkg::*;
(
    input  alu_op_e      alu_op,
    input  logic [2:0]   funct3,
    input  logic         op5,
    input  logic         funct7_5,
    output alu_control_e alu_control
);

    always_comb begin
        alu_control = AluAdd;
        case (alu_op)
            AluOpSub: alu_control = AluSub;
            AluOpFunct: begin
                case (funct3)
                    // Only R-type (op5=1) can encode SUB; ADDI ignores funct7.
                    3'b000:  alu_control = (op5 && funct7_5) ? AluSub : AluAdd;
                    3'b010:  alu_control = AluSlt;
                    3'b110:  alu_control = AluOr;
                    3'b111:  alu_control = AluAnd;
                    default: alu_control = AluAdd;
                endcase
            end
            default: alu_control = AluAdd;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I main control FSM with memory-ready stalls.
// Define ILLEGAL_TRAP_EN to lock into a trap state on unknown opcodes.
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       reg_write,
    output logic [2:0] imm_src,
    output logic [2:0] alu_control,
    output logic       illegal_instr
);

    state_e       state_q;
    logic         pc_update;
    logic         branch;
    logic         adr_sel;
    logic         mem_wr;
    logic         ir_wr;
    logic         reg_wr;
    result_src_e  res_sel;
    src_a_e       a_sel;
    src_b_e       b_sel;
    alu_op_e      alu_op;
    alu_control_e alu_ctl;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StFetch;
        end else begin
            unique case (state_q)
                StFetch:  if (mem_ready) state_q <= StDecode;
                StDecode: begin
                    case (op)
                        OpLoad, OpStore: state_q <= StMemAdr;
                        OpRtype:         state_q <= StExecuteR;
                        OpItype:         state_q <= StExecuteI;
                        OpJal:           state_q <= StJal;
                        OpBranch:        state_q <= StBranch;
`ifdef ILLEGAL_TRAP_EN
                        default:         state_q <= StTrap;
`else
                        default:         state_q <= StFetch;
`endif
                    endcase
                end
                StMemAdr:   state_q <= op[5] ? StMemWrite : StMemRead;
                StMemRead:  if (mem_ready) state_q <= StMemWb;
                StMemWb:    state_q <= StFetch;
                StMemWrite: if (mem_ready) state_q <= StFetch;
                StExecuteR: state_q <= StAluWb;
                StExecuteI: state_q <= StAluWb;
                StAluWb:    state_q <= StFetch;
                StJal:      state_q <= StAluWb;
                StBranch:   state_q <= StFetch;
                StTrap:     state_q <= StTrap;
                default:    state_q <= StFetch;
            endcase
        end
    end

    always_comb begin
        pc_update = 1'b0;
        branch    = 1'b0;
        adr_sel   = 1'b0;
        mem_wr    = 1'b0;
        ir_wr     = 1'b0;
        reg_wr    = 1'b0;
        res_sel   = ResAluOut;
        a_sel     = SrcAPc;
        b_sel     = SrcBRs2;
        alu_op    = AluOpAdd;
        unique case (state_q)
            StFetch: begin
                b_sel     = SrcBFour;
                res_sel   = ResAluResult;
                ir_wr     = mem_ready;
                pc_update = mem_ready;
            end
            // Branch target is computed here and parked in ALUOut.
            StDecode: begin
                a_sel = SrcAOldPc;
                b_sel = SrcBImm;
            end
            StMemAdr: begin
                a_sel = SrcARs1;
                b_sel = SrcBImm;
            end
            StMemRead: adr_sel = 1'b1;
            StMemWb: begin
                res_sel = ResData;
                reg_wr  = 1'b1;
            end
            StMemWrite: begin
                adr_sel = 1'b1;
                mem_wr  = 1'b1;
            end
            StExecuteR: begin
                a_sel  = SrcARs1;
                b_sel  = SrcBRs2;
                alu_op = AluOpFunct;
            end
            StExecuteI: begin
                a_sel  = SrcARs1;
                b_sel  = SrcBImm;
                alu_op = AluOpFunct;
            end
            StAluWb: reg_wr = 1'b1;
            StJal: begin
                a_sel     = SrcAOldPc;
                b_sel     = SrcBFour;
                pc_update = 1'b1;
            end
            StBranch: begin
                a_sel  = SrcARs1;
                b_sel  = SrcBRs2;
                alu_op = AluOpSub;
                branch = 1'b1;
            end
            StTrap:  ;
            default: ;
        endcase
    end

    multicycle_control_fsm_alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7_5    (funct7_5),
        .alu_control (alu_ctl)
    );

    // Reset is synchronous, so the gating below keeps enables quiet during the reset cycle itself.
    assign pc_write    = rst_n & (pc_update | (branch & (zero ^ funct3[0])));
    assign adr_src     = rst_n & adr_sel;
    assign mem_write   = rst_n & mem_wr;
    assign ir_write    = rst_n & ir_wr;
    assign reg_write   = rst_n & reg_wr;
    assign result_src  = rst_n ? res_sel : ResAluOut;
    assign alu_src_a   = rst_n ? a_sel : SrcAPc;
    assign alu_src_b   = rst_n ? b_sel : SrcBRs2;
    assign imm_src     = rst_n ? imm_src_of(op) : ImmI;
    assign alu_control = rst_n ? alu_ctl : AluAdd;

`ifdef ILLEGAL_TRAP_EN
    assign illegal_instr = rst_n & (state_q == StTrap);
`else
    assign illegal_instr = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench for multicycle_control_fsm against an instruction-level timing model.
// Works with or without ILLEGAL_TRAP_EN defined.
module tb_multicycle_control_fsm;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011, SLT = 3'b101;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] imm_src, alu_control;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .op            (op),
        .funct3        (funct3),
        .funct7_5      (funct7_5),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .adr_src       (adr_src),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .result_src    (result_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .reg_write     (reg_write),
        .imm_src       (imm_src),
        .alu_control   (alu_control),
        .illegal_instr (illegal_instr)
    );

    wire [17:0] obs = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
                       reg_write, imm_src, alu_control, illegal_instr};

    task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t op=%b f3=%b: got %h expected %h", tag, $time, op, funct3, got, exp);
        end
    endtask

    function automatic logic [2:0] imm_for(input logic [6:0] o);
        if (o == OP_SW) return 3'b001;
        if (o == OP_BR) return 3'b010;
        if (o == OP_JAL) return 3'b100;
        return 3'b000;
    endfunction

    // R-type funct3=000 with funct7 bit set is SUB; ADDI never subtracts.
    function automatic logic [2:0] alu_for(input logic [6:0] o, input logic [2:0] f3,
                                           input logic f75);
        case (f3)
            3'b000:  return (o == OP_R && f75) ? SUB : ADD;
            3'b010:  return SLT;
            3'b110:  return OR_;
            3'b111:  return AND_;
            default: return ADD;
        endcase
    endfunction

    function automatic logic [17:0] exp_out(input logic pcw, input logic adr, input logic mw,
                                            input logic irw, input logic [1:0] res,
                                            input logic [1:0] a, input logic [1:0] b,
                                            input logic rw, input logic [2:0] alu,
                                            input logic ill);
        return {pcw, adr, mw, irw, res, a, b, rw, imm_for(op), alu, ill};
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic cycle(input string tag, input logic mr, input logic zr, input logic [17:0] exp);
        mem_ready = mr;
        zero      = zr;
        @(negedge clk);
        check(tag, obs, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input int waits);
        repeat (waits) cycle("fetch_wait", 1'b0, rbit(), exp_out(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 0, ADD, 0));
        cycle("fetch", 1'b1, rbit(), exp_out(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 0, ADD, 0));
    endtask

    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f75,
                             input int fw, input int mw, input logic bz);
        op       = o;
        funct3   = f3;
        funct7_5 = f75;
        do_fetch(fw);
        cycle("decode", rbit(), rbit(), exp_out(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, ADD, 0));
        if (o == OP_LW || o == OP_SW) begin
            cycle("memadr", rbit(), rbit(), exp_out(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, ADD, 0));
            if (o == OP_LW) begin
                repeat (mw) cycle("memread_wait", 1'b0, rbit(), exp_out(0, 1, 0, 0, 0, 0, 0, 0, ADD, 0));
                cycle("memread", 1'b1, rbit(), exp_out(0, 1, 0, 0, 0, 0, 0, 0, ADD, 0));
                cycle("memwb", rbit(), rbit(), exp_out(0, 0, 0, 0, 2'b01, 0, 0, 1, ADD, 0));
            end else begin
                repeat (mw) cycle("memwrite_wait", 1'b0, rbit(), exp_out(0, 1, 1, 0, 0, 0, 0, 0, ADD, 0));
                cycle("memwrite", 1'b1, rbit(), exp_out(0, 1, 1, 0, 0, 0, 0, 0, ADD, 0));
            end
        end else if (o == OP_R || o == OP_I) begin
            cycle("execute", rbit(), rbit(),
                  exp_out(0, 0, 0, 0, 2'b00, 2'b10, (o == OP_I) ? 2'b01 : 2'b00, 0,
                          alu_for(o, f3, f75), 0));
            cycle("aluwb", rbit(), rbit(), exp_out(0, 0, 0, 0, 0, 0, 0, 1, ADD, 0));
        end else if (o == OP_JAL) begin
            cycle("jal", rbit(), rbit(), exp_out(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 0, ADD, 0));
            cycle("aluwb", rbit(), rbit(), exp_out(0, 0, 0, 0, 0, 0, 0, 1, ADD, 0));
        end else if (o == OP_BR) begin
            // BEQ taken when equal, BNE taken when not equal.
            cycle("branch", rbit(), bz,
                  exp_out(f3[0] ? !bz : bz, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, SUB, 0));
        end else begin
`ifdef ILLEGAL_TRAP_EN
            repeat (3) cycle("trap", rbit(), rbit(), exp_out(0, 0, 0, 0, 0, 0, 0, 0, ADD, 1));
            rst_n = 1'b0;
            cycle("trap_reset", rbit(), rbit(), 18'h0);
            rst_n = 1'b1;
`endif
        end
    endtask

    function automatic logic [6:0] illegal_op();
        logic [6:0] o;
        do o = 7'($urandom_range(0, 127));
        while (o == OP_LW || o == OP_SW || o == OP_R || o == OP_I || o == OP_JAL || o == OP_BR);
        return o;
    endfunction

    initial begin
        rst_n     = 1'b0;
        op        = OP_R;
        funct3    = 3'b000;
        funct7_5  = 1'b0;
        zero      = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) cycle("reset", 1'b1, 1'b0, 18'h0);
        rst_n = 1'b1;

        run_instr(OP_R, 3'b000, 1'b0, 0, 0, 1'b0);
        run_instr(OP_R, 3'b000, 1'b1, 1, 0, 1'b0);
        run_instr(OP_LW, 3'b010, 1'b0, 0, 2, 1'b0);
        run_instr(OP_SW, 3'b010, 1'b0, 2, 3, 1'b0);
        run_instr(OP_BR, 3'b000, 1'b0, 0, 0, 1'b1);
        run_instr(OP_BR, 3'b001, 1'b0, 0, 0, 1'b1);
        run_instr(OP_JAL, 3'b000, 1'b0, 0, 0, 1'b0);
        run_instr(7'b1111111, 3'b000, 1'b0, 0, 0, 1'b0);
        run_instr(OP_I, 3'b111, 1'b1, 0, 0, 1'b0);

        // Reset arriving while a store is stalled must drop mem_write in the same cycle.
        op     = OP_SW;
        funct3 = 3'b010;
        do_fetch(0);
        cycle("decode", 1'b0, 1'b0, exp_out(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, ADD, 0));
        cycle("memadr", 1'b0, 1'b0, exp_out(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, ADD, 0));
        cycle("memwrite_wait", 1'b0, 1'b0, exp_out(0, 1, 1, 0, 0, 0, 0, 0, ADD, 0));
        rst_n = 1'b0;
        cycle("memwrite_reset", 1'b0, 1'b0, 18'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 300; i++) begin
            logic [6:0] o;
            logic [2:0] f3;
            case ($urandom_range(0, 6))
                0: o = OP_LW;
                1: o = OP_SW;
                2: o = OP_R;
                3: o = OP_I;
                4: o = OP_JAL;
                5: o = OP_BR;
                default: o = illegal_op();
            endcase
            f3 = (o == OP_BR) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(0, 7));
            run_instr(o, f3, rbit(), $urandom_range(0, 3), $urandom_range(0, 3), rbit());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
